// File: rtl/seg_display_mux_n_if.sv
// Value handshake bundle for seg_display_mux_n: value, valid/ready, completion and overflow.
// With SEG_HEX_MODE_EN defined, the bundle also carries hex_mode.
interface seg_display_mux_n_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] value_in;
    logic              value_valid;
    logic              value_ready;
    logic              conv_done;
    logic              overflow;
`ifdef SEG_HEX_MODE_EN
    logic              hex_mode;

    modport master (
        output value_in, value_valid, hex_mode,
        input  value_ready, conv_done, overflow
    );
    modport slave (
        input  value_in, value_valid, hex_mode,
        output value_ready, conv_done, overflow
    );
`else
    modport master (
        output value_in, value_valid,
        input  value_ready, conv_done, overflow
    );
    modport slave (
        input  value_in, value_valid,
        output value_ready, conv_done, overflow
    );
`endif
endinterface

// File: rtl/seg_display_mux_n.sv
// Binary-to-BCD (iterative double-dabble) converter driving a scanned common-cathode
// 7-segment display. Optional raw-hex path enabled by the SEG_HEX_MODE_EN macro.
module seg_display_mux_n #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 10000
) (
    input  logic                  clk,
    input  logic                  rstb,
    seg_display_mux_n_if.slave    bus,
    input  logic                  blank_en,
    output logic [NUM_DIGITS-1:0] digit,
    output logic [6:0]            seg_data
);

    // Accumulator holds 2^DATA_W-1 in BCD and is never narrower than the display.
    localparam int unsigned MIN_NIB = (DATA_W * 302 + 999) / 1000 + 1;
    localparam int unsigned BCD_N   = (MIN_NIB > NUM_DIGITS) ? MIN_NIB : NUM_DIGITS;
    localparam int unsigned BCD_W   = 4 * BCD_N;
    localparam int unsigned DISP_W  = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W   = $clog2(DATA_W);
    localparam int unsigned PRE_W   = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StUpdate} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [BCD_W-1:0]    bcd_adj;
    logic [CNT_W-1:0]    iter_q;
    logic [DISP_W-1:0]   disp_q;
    logic                ready_q;
    logic                done_q;
    logic                ovf_q;
    logic                upper_nz;
    logic                hex_sel;

    logic [PRE_W-1:0]      pre_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      msd;
    logic [3:0]            cur_nib;
    logic                  blank_pos;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] digit_q;
    logic [6:0]            seg_q;

`ifdef SEG_HEX_MODE_EN
    assign hex_sel = bus.hex_mode;
`else
    assign hex_sel = 1'b0;
`endif

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        upper_nz = 1'b0;
        for (int unsigned i = NUM_DIGITS; i < BCD_N; i++) begin
            upper_nz = upper_nz | (|bcd_q[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            shift_q <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            disp_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (bus.value_valid && ready_q) begin
                        ready_q <= 1'b0;
                        if (hex_sel) begin
                            // Raw nibbles go straight into the accumulator; no conversion.
                            bcd_q   <= BCD_W'(bus.value_in);
                            state_q <= StUpdate;
                        end else begin
                            shift_q <= bus.value_in;
                            bcd_q   <= '0;
                            iter_q  <= '0;
                            state_q <= StConv;
                        end
                    end
                end
                StConv: begin
                    {bcd_q, shift_q} <= {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
                    iter_q           <= iter_q + 1'b1;
                    if (iter_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= StUpdate;
                    end
                end
                StUpdate: begin
                    disp_q  <= bcd_q[DISP_W-1:0];
                    ovf_q   <= upper_nz;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.value_ready = ready_q;
    assign bus.conv_done   = done_q;
    assign bus.overflow    = ovf_q;

    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
`ifdef SEG_HEX_MODE_EN
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
`endif
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        msd = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (|disp_q[4*i +: 4]) begin
                msd = IDX_W'(i);
            end
        end
    end

    // Position 0 can never exceed msd, so it is never blanked.
    assign cur_nib   = disp_q[4*idx_q +: 4];
    assign blank_pos = blank_en && (idx_q > msd);

    always_comb begin
        seg_next = seg_lut(cur_nib);
        if (ovf_q) begin
            seg_next = 7'h40;
        end else if (blank_pos) begin
            seg_next = 7'h00;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pre_q   <= '0;
            idx_q   <= '0;
            digit_q <= '0;
            seg_q   <= '0;
        end else begin
            if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            digit_q <= NUM_DIGITS'(1) << idx_q;
            seg_q   <= seg_next;
        end
    end

    assign digit    = digit_q;
    assign seg_data = seg_q;

endmodule

// File: tb/tb_seg_display_mux_n.sv
// Directed, table-driven bench for seg_display_mux_n: an 8-digit instance for decimal
// display and blanking, and a 4-digit instance for overflow.
module tb_seg_display_mux_n;

    logic       clk = 1'b0;
    logic       rstb;
    logic       blank_en;
    logic [7:0] digit8;
    logic [3:0] digit4;
    logic [6:0] seg8;
    logic [6:0] seg4;

    int vec = 0;
    int err = 0;

    seg_display_mux_n_if #(.DATA_W(16)) if8 ();
    seg_display_mux_n_if #(.DATA_W(16)) if4 ();

    seg_display_mux_n #(.DATA_W(16), .NUM_DIGITS(8), .SCAN_DIV(4)) dut8 (
        .clk      (clk),
        .rstb     (rstb),
        .bus      (if8),
        .blank_en (blank_en),
        .digit    (digit8),
        .seg_data (seg8)
    );

    seg_display_mux_n #(.DATA_W(16), .NUM_DIGITS(4), .SCAN_DIV(4)) dut4 (
        .clk      (clk),
        .rstb     (rstb),
        .bus      (if4),
        .blank_en (blank_en),
        .digit    (digit4),
        .seg_data (seg4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          sel4;
        logic [15:0] value;
        bit          blank;
        bit          ovf;
        logic [63:0] seg;   // byte p = expected seg_data at digit position p
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic read_pos(input bit sel4, input int pos, output logic [7:0] s);
        logic [7:0] d;
        int         n;
        n = 0;
        @(negedge clk);
        d = sel4 ? {4'b0, digit4} : digit8;
        while (d != (8'(1) << pos) && n < 80) begin
            @(negedge clk);
            n++;
            d = sel4 ? {4'b0, digit4} : digit8;
        end
        if (n >= 80) check($sformatf("digit pos%0d timeout", pos), d, 8'(1) << pos);
        s = sel4 ? {1'b0, seg4} : {1'b0, seg8};
    endtask

    task automatic check_display(input bit sel4, input logic [63:0] exp, input string tag);
        logic [7:0] s;
        int         nd;
        nd = sel4 ? 4 : 8;
        for (int p = 0; p < nd; p++) begin
            read_pos(sel4, p, s);
            check($sformatf("%s seg pos%0d", tag, p), s, exp[8*p +: 8]);
        end
    endtask

    // Accept v on the next ready; lat = edges from accept to the conv_done pulse.
    task automatic start_conv(input bit sel4, input logic [15:0] v, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel4 ? if4.value_ready : if8.value_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready wait timeout", 0, 1);
        if (sel4) begin
            if4.value_in = v;
            if4.value_valid = 1'b1;
        end else begin
            if8.value_in = v;
            if8.value_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        if4.value_valid = 1'b0;
        if8.value_valid = 1'b0;
        lat = 0;
        while (!(sel4 ? if4.conv_done : if8.conv_done) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        tbl[0]  = '{1'b0, 16'd0,     1'b1, 1'b0, 64'h00000000_0000003F};
        tbl[1]  = '{1'b0, 16'd0,     1'b0, 1'b0, 64'h3F3F3F3F_3F3F3F3F};
        tbl[2]  = '{1'b0, 16'd1234,  1'b1, 1'b0, 64'h00000000_065B4F66};
        tbl[3]  = '{1'b0, 16'd1234,  1'b0, 1'b0, 64'h3F3F3F3F_065B4F66};
        tbl[4]  = '{1'b0, 16'd65535, 1'b1, 1'b0, 64'h0000007D_6D6D4F6D};
        tbl[5]  = '{1'b0, 16'd100,   1'b1, 1'b0, 64'h00000000_00063F3F};
        tbl[6]  = '{1'b0, 16'd9087,  1'b1, 1'b0, 64'h00000000_6F3F7F07};
        tbl[7]  = '{1'b1, 16'd65535, 1'b0, 1'b1, 64'h00000000_40404040};
        tbl[8]  = '{1'b1, 16'd9999,  1'b1, 1'b0, 64'h00000000_6F6F6F6F};
        tbl[9]  = '{1'b1, 16'd10000, 1'b1, 1'b1, 64'h00000000_40404040};
        tbl[10] = '{1'b1, 16'd12,    1'b1, 1'b0, 64'h00000000_0000065B};

        rstb = 1'b0;
        blank_en = 1'b0;
        if8.value_in = '0;
        if8.value_valid = 1'b0;
        if4.value_in = '0;
        if4.value_valid = 1'b0;
`ifdef SEG_HEX_MODE_EN
        if8.hex_mode = 1'b0;
        if4.hex_mode = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("reset value_ready", if8.value_ready, 0);
        check("reset conv_done", if8.conv_done, 0);
        check("reset overflow", if8.overflow, 0);
        check("reset digit", digit8, 0);
        check("reset seg_data", seg8, 0);
        check("reset digit4", digit4, 0);
        rstb = 1'b1;

        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) check("ready after release", if8.value_ready, 1);
            check($sformatf("scan digit n%0d", n), digit8, 8'(1) << (((n - 1) / 4) % 8));
            check($sformatf("scan seg n%0d", n), seg8, 7'h3F);
        end
        blank_en = 1'b1;
        check_display(1'b0, 64'h3F, "reset blank");

        for (int i = 0; i < 11; i++) begin
            blank_en = tbl[i].blank;
            start_conv(tbl[i].sel4, tbl[i].value, lat);
            check($sformatf("v%0d latency", i), lat, 17);
            check($sformatf("v%0d ready low at done", i),
                  tbl[i].sel4 ? if4.value_ready : if8.value_ready, 0);
            @(negedge clk);
            check($sformatf("v%0d ready back", i),
                  tbl[i].sel4 ? if4.value_ready : if8.value_ready, 1);
            check($sformatf("v%0d overflow", i),
                  tbl[i].sel4 ? if4.overflow : if8.overflow, tbl[i].ovf);
            check_display(tbl[i].sel4, tbl[i].seg, $sformatf("v%0d", i));
        end

        // value_valid held through CONV with a different value must be ignored.
        blank_en = 1'b1;
        @(negedge clk);
        while (!if8.value_ready) @(negedge clk);
        if8.value_in = 16'd1234;
        if8.value_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.value_in = 16'd4321;
        ndone = 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (if8.conv_done) begin
                ndone++;
                if (ndone == 1) lat = n - 1;
                if8.value_valid = 1'b0;
            end
            @(negedge clk);
        end
        if8.value_valid = 1'b0;
        check("hold-valid conv_done count", ndone, 1);
        check("hold-valid latency", lat, 17);
        check_display(1'b0, 64'h00000000_065B4F66, "hold-valid");

        // Reset eight edges into a conversion: no conv_done, display back to zero.
        @(negedge clk);
        while (!if8.value_ready) @(negedge clk);
        if8.value_in = 16'd9087;
        if8.value_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.value_valid = 1'b0;
        repeat (8) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        check("midconv reset conv_done", if8.conv_done, 0);
        check("midconv reset digit", digit8, 0);
        rstb = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) check("midconv ready after release", if8.value_ready, 1);
            if (if8.conv_done) ndone++;
        end
        check("midconv conv_done count", ndone, 0);
        check_display(1'b0, 64'h3F, "midconv display");

`ifdef SEG_HEX_MODE_EN
        blank_en = 1'b1;
        if8.hex_mode = 1'b1;
        start_conv(1'b0, 16'hBEEF, lat);
        if8.hex_mode = 1'b0;
        check("hex latency", lat, 1);
        check("hex overflow", if8.overflow, 0);
        check_display(1'b0, 64'h00000000_7C797971, "hex");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
